// File: rtl/control_segmentado_if.sv
// Bundle between the ID-stage decoder/hazard inputs and the pipelined
// control-path outputs of control_segmentado.
interface control_segmentado_if;
  localparam int unsigned CW = 10;
  localparam int unsigned RW = 5;

  logic [CW-1:0] Control;
  logic [RW-1:0] rs_id;
  logic [RW-1:0] rt_id;
  logic          cero_mem;

  logic          RegDest_ex;
  logic          FuenteALU_ex;
  logic [1:0]    ALUOp_ex;
  logic          LeerMem_mem;
  logic          EscrMem_mem;
  logic          MemaReg_wb;
  logic          EscrReg_wb;
  logic          tomar_salto;
  logic          escr_pc;
  logic          escr_ifid;
  logic          flush_ifid;

  modport master (
    output Control, rs_id, rt_id, cero_mem,
    input  RegDest_ex, FuenteALU_ex, ALUOp_ex, LeerMem_mem, EscrMem_mem,
           MemaReg_wb, EscrReg_wb, tomar_salto, escr_pc, escr_ifid, flush_ifid
  );

  modport slave (
    input  Control, rs_id, rt_id, cero_mem,
    output RegDest_ex, FuenteALU_ex, ALUOp_ex, LeerMem_mem, EscrMem_mem,
           MemaReg_wb, EscrReg_wb, tomar_salto, escr_pc, escr_ifid, flush_ifid
  );
endinterface

// File: rtl/control_segmentado.sv
// Pipelined control path: carries the ID control word through ID/EX, EX/MEM and
// MEM/WB, stalls on load-use hazards and flushes on jumps resolved in MEM.
module control_segmentado (
  input  logic                 clk,
  input  logic                 rst_n,
  control_segmentado_if.slave  bus
);
  localparam int unsigned CW = 10;
  localparam int unsigned RW = 5;
  localparam int unsigned MW = 6;
  localparam int unsigned WW = 2;

  localparam int unsigned B_SALTOINCOND = 9;
  localparam int unsigned B_REGDEST     = 8;
  localparam int unsigned B_FUENTEALU   = 7;
  localparam int unsigned B_MEMAREG     = 6;
  localparam int unsigned B_ESCRREG     = 5;
  localparam int unsigned B_LEERMEM     = 4;
  localparam int unsigned B_ESCRMEM     = 3;
  localparam int unsigned B_SALTOCOND   = 2;

  // EX/MEM field positions: {Saltoincond, MemaReg, EscrReg, LeerMem, EscrMem, SaltoCond}
  localparam int unsigned M_SALTOINCOND = 5;
  localparam int unsigned M_MEMAREG     = 4;
  localparam int unsigned M_ESCRREG     = 3;
  localparam int unsigned M_LEERMEM     = 2;
  localparam int unsigned M_ESCRMEM     = 1;
  localparam int unsigned M_SALTOCOND   = 0;

  // MEM/WB field positions: {MemaReg, EscrReg}
  localparam int unsigned W_MEMAREG = 1;
  localparam int unsigned W_ESCRREG = 0;

  logic [CW-1:0] idex_q,  idex_d;
  logic [RW-1:0] rt_ex_q, rt_ex_d;
  logic [MW-1:0] exmem_q, exmem_d;
  logic [WW-1:0] memwb_q, memwb_d;

  logic [CW-1:0] ctrl_san;
  logic          load_use;
  logic          taken;
  logic          stall;

  // Hazard detection and branch resolution, all same-cycle
  always_comb begin
    load_use = idex_q[B_LEERMEM] & (rt_ex_q != RW'(0)) &
               ((rt_ex_q == bus.rs_id) | (rt_ex_q == bus.rt_id));
    taken    = exmem_q[M_SALTOINCOND] | (exmem_q[M_SALTOCOND] & bus.cero_mem);
    stall    = load_use & ~taken;
  end

  // Non-writing instructions carry decoder don't-cares; force them to 0
  always_comb begin
    ctrl_san = bus.Control;
    if (!bus.Control[B_ESCRREG]) begin
      ctrl_san[B_REGDEST] = 1'b0;
      ctrl_san[B_MEMAREG] = 1'b0;
    end
  end

  // Next-state of the stage registers: bubbles on stall, zeros on flush
  always_comb begin
    idex_d  = ctrl_san;
    rt_ex_d = bus.rt_id;
    if (taken || load_use) begin
      idex_d  = '0;
      rt_ex_d = '0;
    end

    exmem_d = {idex_q[B_SALTOINCOND], idex_q[B_MEMAREG], idex_q[B_ESCRREG],
               idex_q[B_LEERMEM],     idex_q[B_ESCRMEM], idex_q[B_SALTOCOND]};
    if (taken) begin
      exmem_d = '0;
    end

    memwb_d = {exmem_q[M_MEMAREG], exmem_q[M_ESCRREG]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      rt_ex_q <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      rt_ex_q <= rt_ex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.RegDest_ex   = idex_q[B_REGDEST];
  assign bus.FuenteALU_ex = idex_q[B_FUENTEALU];
  assign bus.ALUOp_ex     = idex_q[1:0];
  assign bus.LeerMem_mem  = exmem_q[M_LEERMEM];
  assign bus.EscrMem_mem  = exmem_q[M_ESCRMEM];
  assign bus.MemaReg_wb   = memwb_q[W_MEMAREG];
  assign bus.EscrReg_wb   = memwb_q[W_ESCRREG];

  // A taken jump wins over a stall: the stalled instruction is being flushed anyway
  assign bus.tomar_salto  = taken;
  assign bus.escr_pc      = ~stall;
  assign bus.escr_ifid    = ~stall;
  assign bus.flush_ifid   = taken;
endmodule

// File: tb/tb_control_segmentado.sv
// Self-checking bench for control_segmentado: directed scenarios plus random
// traffic compared against an instruction-level pipeline model.
module tb_control_segmentado;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  control_segmentado_if bus ();

  control_segmentado dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the control word of the instruction sitting in each stage
  logic [9:0] m_ex, m_mem, m_wb;
  logic [4:0] m_rt;
  logic [9:0] m_ctrl;
  logic [4:0] m_rs, m_rtid;
  logic       m_cz;

  localparam logic [9:0] LW   = 10'b0011110000;
  localparam logic [9:0] ADD  = 10'b0100100010;
  localparam logic [9:0] BEQ  = 10'b0000000101;
  localparam logic [9:0] JMP  = 10'b1000000000;
  localparam logic [9:0] STR  = 10'b0000001000;
  localparam logic [9:0] NOP  = 10'b0000000000;
  localparam logic [9:0] SW1  = 10'b0111001000;
  localparam logic [9:0] SWX  = 10'b0x1x001000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] sanitize(input logic [9:0] c);
    logic [9:0] r;
    r = c;
    if (c[5] !== 1'b1) begin
      r[8] = 1'b0;
      r[6] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic hazard();
    return m_ex[4] && (m_rt != 5'd0) && ((m_rt == m_rs) || (m_rt == m_rtid));
  endfunction

  function automatic logic jump();
    return m_mem[9] || (m_mem[2] && m_cz);
  endfunction

  task automatic check_all();
    logic tk;
    logic st;
    tk = jump();
    st = hazard() && !tk;
    check("regdest_ex",   32'(bus.RegDest_ex),   32'(m_ex[8]));
    check("fuentealu_ex", 32'(bus.FuenteALU_ex), 32'(m_ex[7]));
    check("aluop_ex",     32'(bus.ALUOp_ex),     32'(m_ex[1:0]));
    check("leermem_mem",  32'(bus.LeerMem_mem),  32'(m_mem[4]));
    check("escrmem_mem",  32'(bus.EscrMem_mem),  32'(m_mem[3]));
    check("memareg_wb",   32'(bus.MemaReg_wb),   32'(m_wb[6]));
    check("escrreg_wb",   32'(bus.EscrReg_wb),   32'(m_wb[5]));
    check("tomar_salto",  32'(bus.tomar_salto),  32'(tk));
    check("escr_pc",      32'(bus.escr_pc),      32'(!st));
    check("escr_ifid",    32'(bus.escr_ifid),    32'(!st));
    check("flush_ifid",   32'(bus.flush_ifid),   32'(tk));
  endtask

  task automatic model_reset();
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    m_rt  = '0;
  endtask

  // Advance the model one instruction slot at the rising edge
  task automatic tick();
    logic tk;
    logic hz;
    @(posedge clk);
    tk = jump();
    hz = hazard();
    m_wb  = m_mem;
    m_mem = tk ? 10'd0 : m_ex;
    if (tk || hz) begin
      m_ex = '0;
      m_rt = '0;
    end else begin
      m_ex = m_ctrl;
      m_rt = m_rtid;
    end
  endtask

  task automatic drive(input logic [9:0] c, input int rs, input int rt, input logic cz);
    @(negedge clk);
    bus.Control  = c;
    bus.rs_id    = 5'(rs);
    bus.rt_id    = 5'(rt);
    bus.cero_mem = cz;
    m_ctrl = sanitize(c);
    m_rs   = 5'(rs);
    m_rtid = 5'(rt);
    m_cz   = cz;
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_escr_pc", 32'(bus.escr_pc), 1);
    check("rst_flush",   32'(bus.flush_ifid), 0);
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic flush_pipe();
    repeat (4) begin
      drive(NOP, 0, 0, 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] c;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.Control  = '0;
    bus.rs_id    = '0;
    bus.rt_id    = '0;
    bus.cero_mem = 1'b0;
    m_ctrl = '0;
    m_rs   = '0;
    m_rtid = '0;
    m_cz   = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_all();
    check("init_escr_pc",   32'(bus.escr_pc), 1);
    check("init_escr_ifid", 32'(bus.escr_ifid), 1);
    check("init_escrreg",   32'(bus.EscrReg_wb), 0);
    rst_n = 1'b1;
    tick();

    // Propagation of a load through EX, MEM, WB
    drive(LW, 1, 9, 1'b0); tick();
    drive(NOP, 0, 0, 1'b0);
    check("prop_fuente_ex", 32'(bus.FuenteALU_ex), 1);
    tick();
    drive(NOP, 0, 0, 1'b0);
    check("prop_leermem_mem", 32'(bus.LeerMem_mem), 1);
    tick();
    drive(NOP, 0, 0, 1'b0);
    check("prop_memareg_wb", 32'(bus.MemaReg_wb), 1);
    check("prop_escrreg_wb", 32'(bus.EscrReg_wb), 1);
    tick();
    flush_pipe();

    // Load-use stall, front end re-presents the stalled instruction
    drive(LW, 1, 5, 1'b0); tick();
    drive(ADD, 5, 2, 1'b0);
    check("stall_escr_pc",   32'(bus.escr_pc), 0);
    check("stall_escr_ifid", 32'(bus.escr_ifid), 0);
    tick();
    drive(ADD, 5, 2, 1'b0);
    check("bubble_fuente_ex", 32'(bus.FuenteALU_ex), 0);
    check("bubble_aluop_ex",  32'(bus.ALUOp_ex), 0);
    check("bubble_escr_pc",   32'(bus.escr_pc), 1);
    tick();
    flush_pipe();

    // Load with rt = 0 never stalls
    drive(LW, 1, 0, 1'b0); tick();
    drive(ADD, 0, 0, 1'b0);
    check("rt0_escr_pc", 32'(bus.escr_pc), 1);
    tick();
    flush_pipe();

    // Taken conditional branch flushes EX and MEM
    drive(BEQ, 1, 2, 1'b0); tick();
    drive(STR, 3, 4, 1'b0); tick();
    drive(LW, 0, 0, 1'b1);
    check("br_tomar", 32'(bus.tomar_salto), 1);
    check("br_flush", 32'(bus.flush_ifid), 1);
    tick();
    drive(NOP, 0, 0, 1'b0);
    check("br_fuente_ex",  32'(bus.FuenteALU_ex), 0);
    check("br_escrmem_mem", 32'(bus.EscrMem_mem), 0);
    check("br_tomar_next", 32'(bus.tomar_salto), 0);
    tick();
    flush_pipe();

    // Branch not taken
    drive(BEQ, 1, 2, 1'b1); tick();
    drive(NOP, 0, 0, 1'b1); tick();
    drive(NOP, 0, 0, 1'b0);
    check("nbr_tomar", 32'(bus.tomar_salto), 0);
    check("nbr_flush", 32'(bus.flush_ifid), 0);
    tick();
    flush_pipe();

    // Unconditional jump
    drive(JMP, 0, 0, 1'b0); tick();
    drive(NOP, 0, 0, 1'b0); tick();
    drive(ADD, 0, 0, 1'b0);
    check("jmp_tomar", 32'(bus.tomar_salto), 1);
    tick();
    flush_pipe();

    // Taken branch in MEM together with a load-use match
    drive(BEQ, 0, 0, 1'b0); tick();
    drive(LW, 1, 5, 1'b0); tick();
    drive(ADD, 5, 6, 1'b1);
    check("sim_escr_pc",   32'(bus.escr_pc), 1);
    check("sim_escr_ifid", 32'(bus.escr_ifid), 1);
    check("sim_flush",     32'(bus.flush_ifid), 1);
    tick();
    flush_pipe();

    // Store with don't-care bits driven to 1, then to X
    drive(SW1, 1, 2, 1'b0); tick();
    drive(SWX, 1, 2, 1'b0);
    check("sw_regdest_ex", 32'(bus.RegDest_ex), 0);
    tick();
    drive(NOP, 0, 0, 1'b0);
    check("swx_regdest_ex", 32'(bus.RegDest_ex), 0);
    check("sw_escrmem_mem", 32'(bus.EscrMem_mem), 1);
    tick();
    drive(NOP, 0, 0, 1'b0);
    check("swx_escrmem_mem", 32'(bus.EscrMem_mem), 1);
    check("sw_memareg_wb",   32'(bus.MemaReg_wb), 0);
    tick();
    drive(NOP, 0, 0, 1'b0);
    check("swx_memareg_wb", 32'(bus.MemaReg_wb), 0);
    tick();

    // Reset with loads/branches in flight
    drive(LW, 1, 5, 1'b0); tick();
    drive(ADD, 2, 3, 1'b0); tick();
    mid_reset();

    // Random traffic, biased towards loads and register collisions
    for (int i = 0; i < 600; i++) begin
      c = 10'($urandom);
      if ($urandom_range(0, 7) != 0) c[9] = 1'b0;
      if ($urandom_range(0, 3) == 0) c = LW;
      drive(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
      tick();
      if ($urandom_range(0, 59) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
